seq_alu_top: RTL and testbench
==============================

Name: seq_alu_top

Overview:
Parametrised, clocked successor to the lab-1 switch/LED ALU top level. It captures two W-bit operands and an op code on a start pulse, then computes one of four results:
- add and sub in a single cycle;
- unsigned multiply and unsigned divide over W iterations.

The result, overflow flag and status drive LEDs and an active-low hex 7-segment bank. It sits directly under the board top level and is fed by switches and debounced keys.

Parameters:
W, 6, operand width in bits (W >= 2).
DIGITS, 5, number of 7-segment digits; DIGITS*4 >= 2W required.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
a_in  input  W  operand A (switches)
b_in  input  W  operand B (switches)
op_in  input  2  00 add, 01 sub, 10 mul, 11 div
start_in  input  1  one-cycle synchronous start pulse
show_result_in  input  1  1: LEDs and 7-seg show c_out; 0: show {a_in,b_in}
c_out  output  2W  result register
overflow_out  output  1  overflow / divide-by-zero flag
busy_out  output  1  operation in progress
done_out  output  1  one-cycle completion pulse
ledr_out  output  2W  LED mirror of selected display source
seg7_out  output  8*DIGITS  active-low segments, digit d at bits [8d+7:8d], order {dp,g,f,e,d,c,b,a}

Behaviour:
- Single clock domain. Reset is asynchronous and active-low: clk, rst_n.
- Reset state: state IDLE; c_out=0, overflow_out=0, busy_out=0, done_out=0, ledr_out=0, seg7_out all ones (blank).
- FSM states IDLE, RUN, DONE.
  - IDLE: start_in=1 captures a_in, b_in, op_in into internal registers.
    - add/sub go straight to DONE.
    - mul/div go to RUN with iteration counter = W-1, busy_out=1.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle. When counter reaches 0, go to DONE.
  - DONE: c_out and overflow_out update, done_out=1 for exactly this cycle, busy_out=0, then IDLE.
- Latency (start cycle = 0): add/sub: done_out high in cycle 1. mul/div: busy_out high in cycles 1..W, done_out high in cycle W+1.
- start_in while busy or in DONE is ignored. Operand switches changing mid-operation have no effect.
- c_out and overflow_out hold their values until the next DONE.
- Add/sub: W-bit two's-complement result r.
  - c_out = r sign-extended to 2W.
  - overflow_out = signed overflow: operands of equal sign (add) or opposite sign (sub) and sign of r differs from A.
- Mul: unsigned, c_out = full 2W product, overflow_out = 0.
- Div: unsigned, c_out = {remainder, quotient}.
  - b=0: quotient all ones, remainder = a, overflow_out = 1. Still takes W+1 cycles.
- Display source S (2W bits) = show_result_in ? c_out : {a_in,b_in}.
  - ledr_out and seg7_out are registered: one cycle after S changes.
- Digit d < ceil(2W/4) shows hex nibble S[4d+3:4d]; the top nibble is zero-padded. Higher digits are blank (all ones). dp is always 1 (off).
- rst_n low mid-operation aborts immediately to the reset state. The partial result is discarded.

Decomposition:
- Package seq_alu_pkg holds:
  - op code constants OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - FSM state enum;
  - the 16-entry active-low hex-to-segment constant table.
- One sub-module, seq_alu_iter: iterative unsigned W-bit mul/div datapath with start/step/last control from the FSM. Add/sub, FSM and display stay in seq_alu_top.

Test Plan:
(W=6, DIGITS=5)
- Reset: rst_n=0 -> all outputs at reset values, seg7_out = 40'hFF_FFFF_FFFF.
- add: a=31, b=1, start -> cycle 1: done_out=1, c_out=0xFE0, overflow_out=1.
- sub: a=5, b=7 -> c_out=0xFFE, overflow_out=0, done_out in cycle 1.
- mul: a=63, b=63 -> busy_out cycles 1..6, done_out in cycle 7, c_out=0xF81, overflow_out=0.
  - start pulse in cycle 3 ignored, result unchanged.
- div: a=45, b=7 -> c_out=0x0C6, overflow_out=0.
  - a=9, b=0 -> c_out=0x27F, overflow_out=1.
- Display and abort:
  - show_result_in=1 after mul -> seg7 digits 0..2 = ~"1",~"8",~"F", digits 3..4 blank.
  - rst_n pulsed low in cycle 3 of a mul -> outputs reset asynchronously; no done_out follows.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared op codes, FSM states and 7-segment table for seq_alu
package seq_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex nibble (entry 0 at the LSBs).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seq_alu_iter.sv
// rtl/seq_alu_iter.sv - iterative unsigned W-bit shift-add multiply / restoring divide
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture a, b and is_div; clears the partial result
//   is_div     : 1 selects divide, 0 multiply (sampled on load)
//   step       : perform one iteration
//   a, b       : operands (mul: a*b; div: a/b)
//   p_next     : value the result register takes on this step; after the
//                W-th step it is the product, or {remainder, quotient}
module seq_alu_iter #(
    parameter int W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           is_div,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p_next
);

    // p holds {high half, low half}: mul {partial sum, remaining multiplier},
    // div {partial remainder, dividend bits shifting into quotient}.
    logic [2*W-1:0] p;
    logic [W-1:0]   operand_b;
    logic           div_mode;

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        sum     = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, operand_b} : '0);
        shifted = {p[2*W-1:W], p[W-1]};
        diff    = shifted - {1'b0, operand_b};
        if (!div_mode) begin
            p_next = {sum, p[W-1:1]};
        end else if (!diff[W]) begin
            // No borrow: the divisor fits, keep the difference and shift in a 1.
            // A zero divisor always fits, so the quotient saturates to all ones
            // and the dividend ends up in the remainder half.
            p_next = {diff[W-1:0], p[W-2:0], 1'b1};
        end else begin
            p_next = {shifted[W-1:0], p[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p         <= '0;
            operand_b <= '0;
            div_mode  <= 1'b0;
        end else if (load) begin
            p         <= {{W{1'b0}}, a};
            operand_b <= b;
            div_mode  <= is_div;
        end else if (step) begin
            p         <= p_next;
        end
    end

endmodule

// File: rtl/seq_alu_top.sv
// rtl/seq_alu_top.sv - sequential ALU (add/sub/mul/div) with LED and hex display output
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   a_in, b_in, op_in : operands and op code, captured on start_in in IDLE
//   start_in          : one-cycle start pulse, ignored unless IDLE
//   show_result_in    : display c_out (1) or {a_in, b_in} (0)
//   c_out             : result register (2W bits)
//   overflow_out      : signed add/sub overflow or divide-by-zero
//   busy_out          : mul/div iterating
//   done_out          : one-cycle completion pulse
//   ledr_out          : registered copy of the display source
//   seg7_out          : registered active-low 7-segment digits {dp,g..a}
module seq_alu_top
    import seq_alu_pkg::*;
#(
    parameter int W      = 6,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W-1:0]          a_in,
    input  logic [W-1:0]          b_in,
    input  logic [1:0]            op_in,
    input  logic                  start_in,
    input  logic                  show_result_in,
    output logic [2*W-1:0]        c_out,
    output logic                  overflow_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [2*W-1:0]        ledr_out,
    output logic [8*DIGITS-1:0]   seg7_out
);

    localparam int NIB = (2 * W + 3) / 4;
    localparam int CW  = $clog2(W);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           div_q;
    logic           b_zero_q;
    logic           accept;
    logic           iter_load;
    logic           iter_step;
    logic           last_step;
    logic [2*W-1:0] iter_p_next;

    logic           is_sub;
    logic [W-1:0]   addsub_r;
    logic           addsub_ovf;

    logic [2*W-1:0]      disp_src;
    logic [4*DIGITS-1:0] disp_pad;
    logic [8*DIGITS-1:0] seg_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        iter_load = 1'b0;
        iter_step = 1'b0;
        last_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    accept    = 1'b1;
                    iter_load = op_in[1];
                    state_d   = op_in[1] ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                iter_step = 1'b1;
                if (cnt_q == '0) begin
                    last_step = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_out = (state_q == ST_RUN);
    assign done_out = (state_q == ST_DONE);

    // Add/sub finish in the start cycle, straight from the switches.
    always_comb begin
        is_sub     = (op_in == OP_SUB);
        addsub_r   = is_sub ? (a_in - b_in) : (a_in + b_in);
        addsub_ovf = ((a_in[W-1] ^ b_in[W-1]) == is_sub) && (addsub_r[W-1] != a_in[W-1]);
    end

    seq_alu_iter #(.W(W)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (iter_load),
        .is_div (op_in == OP_DIV),
        .step   (iter_step),
        .a      (a_in),
        .b      (b_in),
        .p_next (iter_p_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            div_q        <= 1'b0;
            b_zero_q     <= 1'b0;
            c_out        <= '0;
            overflow_out <= 1'b0;
        end else if (accept) begin
            cnt_q    <= CW'(W - 1);
            div_q    <= (op_in == OP_DIV);
            b_zero_q <= (b_in == '0);
            if (!op_in[1]) begin
                c_out        <= {{W{addsub_r[W-1]}}, addsub_r};
                overflow_out <= addsub_ovf;
            end
        end else if (iter_step) begin
            cnt_q <= cnt_q - 1'b1;
            if (last_step) begin
                c_out        <= iter_p_next;
                overflow_out <= div_q & b_zero_q;
            end
        end
    end

    always_comb begin
        disp_src            = show_result_in ? c_out : {a_in, b_in};
        disp_pad            = '0;
        disp_pad[2*W-1:0]   = disp_src;
        seg_d               = '1;
        for (int d = 0; d < NIB; d++) begin
            seg_d[8*d +: 8] = {1'b1, SEG_TABLE[disp_pad[4*d +: 4]]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr_out <= '0;
            seg7_out <= '1;
        end else begin
            ledr_out <= disp_src;
            seg7_out <= seg_d;
        end
    end

endmodule

// File: tb/tb_seq_alu_top.sv
// tb/tb_seq_alu_top.sv - self-checking bench for seq_alu_top against an arithmetic model
module tb_seq_alu_top;

    localparam int W      = 6;
    localparam int DIGITS = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [W-1:0]    a_in = '0;
    logic [W-1:0]    b_in = '0;
    logic [1:0]      op_in = '0;
    logic            start_in = 1'b0;
    logic            show_result_in = 1'b0;
    logic [2*W-1:0]  c_out;
    logic            overflow_out;
    logic            busy_out;
    logic            done_out;
    logic [2*W-1:0]  ledr_out;
    logic [8*DIGITS-1:0] seg7_out;

    int tests  = 0;
    int failed = 0;

    seq_alu_top #(.W(W), .DIGITS(DIGITS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a_in           (a_in),
        .b_in           (b_in),
        .op_in          (op_in),
        .start_in       (start_in),
        .show_result_in (show_result_in),
        .c_out          (c_out),
        .overflow_out   (overflow_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .ledr_out       (ledr_out),
        .seg7_out       (seg7_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference results from plain integer arithmetic.
    function automatic void model(input int a, input int b, input int op,
                                  output logic [11:0] c, output logic o);
        int sa, sb, t, rs;
        sa = (a >= 32) ? a - 64 : a;
        sb = (b >= 32) ? b - 64 : b;
        case (op)
            0, 1: begin
                t  = (op == 0) ? sa + sb : sa - sb;
                o  = (t > 31) || (t < -32);
                rs = ((t + 96) % 64) - 32;
                c  = 12'(rs);
            end
            2: begin
                c = 12'(a * b);
                o = 1'b0;
            end
            default: begin
                if (b == 0) begin
                    c = 12'((a << 6) | 63);
                    o = 1'b1;
                end else begin
                    c = 12'(((a % b) << 6) | (a / b));
                    o = 1'b0;
                end
            end
        endcase
    endfunction

    function automatic logic [39:0] seg_model(input logic [11:0] s);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return {8'hFF, 8'hFF, tbl[s[11:8]], tbl[s[7:4]], tbl[s[3:0]]};
    endfunction

    // Starts one op; switches wander every following cycle and an extra start
    // pulse is injected in cycle 'poke' (0 = none). Called at posedge+1.
    task automatic run_op(input int a, input int b, input int op, input int poke);
        logic [11:0] ec, cd;
        logic        eo, od;
        int          lat, bcnt, dcnt;
        model(a, b, op, ec, eo);
        lat = 0; bcnt = 0; dcnt = 0; cd = '0; od = 1'b0;
        a_in     = W'(a);
        b_in     = W'(b);
        op_in    = 2'(op);
        start_in = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= W + 4; k++) begin
            start_in = (k == poke);
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            op_in    = 2'($urandom);
            @(negedge clk);
            if (busy_out) bcnt++;
            if (done_out) begin
                dcnt++;
                if (lat == 0) begin
                    lat = k;
                    cd  = c_out;
                    od  = overflow_out;
                end
            end
            @(posedge clk); #1;
        end
        start_in = 1'b0;
        check($sformatf("latency op%0d a%0d b%0d", op, a, b), 64'(lat), 64'((op >= 2) ? W + 1 : 1));
        check($sformatf("done_count op%0d a%0d b%0d", op, a, b), 64'(dcnt), 64'd1);
        check($sformatf("busy_cycles op%0d a%0d b%0d", op, a, b), 64'(bcnt), 64'((op >= 2) ? W : 0));
        check($sformatf("c_out op%0d a%0d b%0d", op, a, b), 64'(cd), 64'(ec));
        check($sformatf("overflow op%0d a%0d b%0d", op, a, b), 64'(od), 64'(eo));
        check($sformatf("c_hold op%0d a%0d b%0d", op, a, b), 64'(c_out), 64'(ec));
    endtask

    initial begin
        int op, a, b, poke, dcnt;
        logic [11:0] ec;
        logic        eo;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_c_out", 64'(c_out), 64'd0);
        check("rst_overflow", 64'(overflow_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_done", 64'(done_out), 64'd0);
        check("rst_ledr", 64'(ledr_out), 64'd0);
        check("rst_seg7", 64'(seg7_out), 64'hFF_FFFF_FFFF);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed ops, including ignored start pulses in RUN and DONE
        run_op(31, 1, 0, 0);
        run_op(5, 7, 1, 1);
        run_op(63, 63, 2, 3);
        run_op(63, 63, 2, W + 1);

        // Display of the mul result
        show_result_in = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("disp_mul_seg7", 64'(seg7_out), 64'hFF_FF8E_80F9);
        check("disp_mul_ledr", 64'(ledr_out), 64'hF81);
        @(posedge clk); #1;
        show_result_in = 1'b0;

        run_op(45, 7, 3, 0);
        run_op(9, 0, 3, 4);

        // Randomized ops
        for (int i = 0; i < 40; i++) begin
            op   = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, 63));
            b    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 63));
            poke = (op >= 2) ? int'($urandom_range(0, W + 1)) : int'($urandom_range(0, 1));
            run_op(a, b, op, poke);
        end

        // Randomized display of switches and of the held result
        model(a, b, op, ec, eo);
        for (int i = 0; i < 8; i++) begin
            show_result_in = i[0];
            a_in = W'($urandom);
            b_in = W'($urandom);
            @(posedge clk); #1;
            @(negedge clk);
            if (i[0]) begin
                check("disp_res_ledr", 64'(ledr_out), 64'(ec));
                check("disp_res_seg7", 64'(seg7_out), 64'(seg_model(ec)));
            end else begin
                check("disp_sw_ledr", 64'(ledr_out), 64'({a_in, b_in}));
                check("disp_sw_seg7", 64'(seg7_out), 64'(seg_model({a_in, b_in})));
            end
            @(posedge clk); #1;
        end
        show_result_in = 1'b0;

        // Abort a mul with reset in cycle 3
        run_op(9, 0, 3, 0);
        a_in = 6'd63; b_in = 6'd63; op_in = 2'b10; start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_busy_before", 64'(busy_out), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_c_out", 64'(c_out), 64'd0);
        check("abort_overflow", 64'(overflow_out), 64'd0);
        check("abort_busy", 64'(busy_out), 64'd0);
        check("abort_done", 64'(done_out), 64'd0);
        check("abort_ledr", 64'(ledr_out), 64'd0);
        check("abort_seg7", 64'(seg7_out), 64'hFF_FFFF_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done_out || busy_out) dcnt++;
        end
        check("abort_no_done", 64'(dcnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
